tree_walker_20: RTL and testbench

- Read-side traversal engine for the tree_rom_20 decision-tree node ROM.
- Accepts a feature vector and walks the tree from the root. At each internal node it issues a ROM address, consumes the registered node word one cycle later, and compares the selected feature against the node threshold.
- Follows the left or right child until it reaches a leaf, then reports the leaf class.
- Sits between the feature front-end and the ensemble vote/aggregation stage; one instance per tree ROM.

---
 rtl/tree_node_pkg.sv | 66 ++++++
 rtl/tree_walker_20_if.sv | 27 ++
 rtl/fp64_le.sv | 36 +++
 rtl/tree_walker_20.sv | 153 +++++++++++++++
 tb/tb_tree_walker_20.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/tree_node_pkg.sv
// Shared decision-tree node layout, FSM states and error causes for the
// tree_rom_20 family of walkers.
package tree_node_pkg;

   localparam int NODE_BITS     = 120;
   localparam int NODE_ID_MSB   = 119;
   localparam int NODE_ID_LSB   = 108;
   localparam int FEAT_MSB      = 107;
   localparam int FEAT_LSB      = 104;
   localparam int THR_MSB       = 103;
   localparam int THR_LSB       = 40;
   localparam int LEFT_MSB      = 39;
   localparam int LEFT_LSB      = 28;
   localparam int RIGHT_MSB     = 27;
   localparam int RIGHT_LSB     = 16;
   localparam int RSVD_MSB      = 15;
   localparam int RSVD_LSB      = 5;
   localparam int LEAF_BIT      = 4;
   localparam int CLASS_MSB     = 3;
   localparam int CLASS_LSB     = 0;

   localparam int CHILD_W       = LEFT_MSB - LEFT_LSB + 1;
   localparam int FP_EXP_W      = 11;
   localparam int FP_MAN_W      = 52;
   localparam int FP_W          = 1 + FP_EXP_W + FP_MAN_W;

   typedef struct packed {
      logic [CHILD_W-1:0]             node_id;
      logic [FEAT_MSB-FEAT_LSB:0]     feat_idx;
      logic [FP_W-1:0]                threshold;
      logic [CHILD_W-1:0]             left;
      logic [CHILD_W-1:0]             right;
      logic [RSVD_MSB-RSVD_LSB:0]     rsvd;
      logic                           is_leaf;
      logic [CLASS_MSB-CLASS_LSB:0]   leaf_class;
   } node_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_EVAL,
      ST_DONE
   } state_e;

   typedef enum logic [2:0] {
      ERR_NONE,
      ERR_NODE_ID,
      ERR_FEAT_IDX,
      ERR_CHILD,
      ERR_DEPTH
   } err_cause_e;

   function automatic node_t unpack_node(input logic [NODE_BITS-1:0] w);
      node_t n;
      n.node_id    = w[NODE_ID_MSB:NODE_ID_LSB];
      n.feat_idx   = w[FEAT_MSB:FEAT_LSB];
      n.threshold  = w[THR_MSB:THR_LSB];
      n.left       = w[LEFT_MSB:LEFT_LSB];
      n.right      = w[RIGHT_MSB:RIGHT_LSB];
      n.rsvd       = w[RSVD_MSB:RSVD_LSB];
      n.is_leaf    = w[LEAF_BIT];
      n.leaf_class = w[CLASS_MSB:CLASS_LSB];
      return n;
   endfunction

endpackage

// File: rtl/tree_walker_20_if.sv
// Request/result and ROM read bus of one tree walker; the walker is the slave
// on the request side and drives the ROM address.
interface tree_walker_20_if #(
   parameter int NODE_WIDTH   = 120,
   parameter int ADDR_WIDTH   = 10,
   parameter int NUM_FEATURES = 16
);
   logic                        start;
   logic [NUM_FEATURES*64-1:0]  feat_in;
   logic                        busy;
   logic [ADDR_WIDTH-1:0]       rom_addr;
   logic [NODE_WIDTH-1:0]       rom_data;
   logic                        done;
   logic [3:0]                  class_out;
   logic                        err;
   logic [5:0]                  depth_out;

   modport slave (
      input  start, feat_in, rom_data,
      output busy, rom_addr, done, class_out, err, depth_out
   );

   modport master (
      output start, feat_in, rom_data,
      input  busy, rom_addr, done, class_out, err, depth_out
   );
endinterface

// File: rtl/fp64_le.sv
// Combinational a <= b on IEEE-754 doubles: +0 equals -0, any NaN operand
// yields false, infinities order normally.
module fp64_le
   import tree_node_pkg::*;
(
   input  logic [FP_W-1:0] a,
   input  logic [FP_W-1:0] b,
   output logic            le
);
   localparam int MAG_W = FP_EXP_W + FP_MAN_W;

   logic [MAG_W-1:0] mag_a;
   logic [MAG_W-1:0] mag_b;
   logic             a_nan;
   logic             b_nan;

   always_comb begin
      mag_a = a[MAG_W-1:0];
      mag_b = b[MAG_W-1:0];
      a_nan = (mag_a[MAG_W-1 -: FP_EXP_W] == '1) && (mag_a[FP_MAN_W-1:0] != '0);
      b_nan = (mag_b[MAG_W-1 -: FP_EXP_W] == '1) && (mag_b[FP_MAN_W-1:0] != '0);
      le    = 1'b0;
      if (a_nan || b_nan) begin
         le = 1'b0;
      end else if ((mag_a == '0) && (mag_b == '0)) begin
         le = 1'b1;
      end else if (a[FP_W-1] != b[FP_W-1]) begin
         le = a[FP_W-1];
      end else if (!a[FP_W-1]) begin
         le = (mag_a <= mag_b);
      end else begin
         // both negative: larger magnitude is the smaller value
         le = (mag_a >= mag_b);
      end
   end
endmodule

// File: rtl/tree_walker_20.sv
// Decision-tree traversal engine: walks tree_rom_20 from the root, one node
// per two cycles (address, then registered node word), and reports the leaf.
module tree_walker_20
   import tree_node_pkg::*;
#(
   parameter int NODE_WIDTH   = 120,
   parameter int ADDR_WIDTH   = 10,
   parameter int ROM_DEPTH    = 512,
   parameter int NUM_FEATURES = 16,
   parameter int MAX_DEPTH    = 32,
   parameter int ROOT_ADDR    = 0
)(
   input  logic             clk,
   input  logic             rst,
   tree_walker_20_if.slave  bus
);
   localparam logic [ADDR_WIDTH-1:0] ROOT = ADDR_WIDTH'(ROOT_ADDR);

   state_e                      state_q;
   state_e                      state_d;
   logic [NUM_FEATURES*64-1:0]  feat_q;
   logic [ADDR_WIDTH-1:0]       rom_addr_q;
   logic [5:0]                  depth_q;
   logic [3:0]                  class_q;
   logic                        err_q;
   logic [5:0]                  depth_out_q;

   logic [NODE_WIDTH-1:0]       node_word;
   node_t                       node;
   logic [FP_W-1:0]             feat_sel;
   logic                        go_left;
   logic [CHILD_W-1:0]          child;
   err_cause_e                  cause;
   logic                        accept;
   logic                        descend;
   logic                        finish;
   logic                        unused_rsvd;

   assign node_word   = bus.rom_data;
   assign node        = unpack_node(node_word[NODE_BITS-1:0]);
   assign unused_rsvd = ^node.rsvd;

   always_comb begin
      feat_sel = '0;
      for (int k = 0; k < NUM_FEATURES; k++) begin
         if (32'(node.feat_idx) == 32'(k)) begin
            feat_sel = feat_q[k*64 +: 64];
         end
      end
   end

   fp64_le u_le (
      .a  (feat_sel),
      .b  (node.threshold),
      .le (go_left)
   );

   assign child = go_left ? node.left : node.right;

   // Error checks in priority order; only the id check applies to leaves.
   always_comb begin
      cause = ERR_NONE;
      if (node.node_id != CHILD_W'(rom_addr_q)) begin
         cause = ERR_NODE_ID;
      end else if (!node.is_leaf) begin
         if (32'(node.feat_idx) >= 32'(NUM_FEATURES)) begin
            cause = ERR_FEAT_IDX;
         end else if (32'(child) >= 32'(ROM_DEPTH)) begin
            cause = ERR_CHILD;
         end else if (depth_q == 6'(MAX_DEPTH)) begin
            cause = ERR_DEPTH;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      descend = 1'b0;
      finish  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               accept  = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            state_d = ST_EVAL;
         end
         ST_EVAL: begin
            if ((cause != ERR_NONE) || node.is_leaf) begin
               finish  = 1'b1;
               state_d = ST_DONE;
            end else begin
               descend = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         feat_q      <= '0;
         rom_addr_q  <= ROOT;
         depth_q     <= '0;
         class_q     <= '0;
         err_q       <= 1'b0;
         depth_out_q <= '0;
      end else begin
         if (accept) begin
            feat_q     <= bus.feat_in;
            rom_addr_q <= ROOT;
            depth_q    <= '0;
         end
         if (descend) begin
            rom_addr_q <= child[ADDR_WIDTH-1:0];
            if (depth_q != 6'(MAX_DEPTH)) begin
               depth_q <= depth_q + 6'd1;
            end
         end
         // results land on the same edge that enters DONE, so they are valid with done
         if (finish) begin
            err_q       <= (cause != ERR_NONE);
            class_q     <= (cause != ERR_NONE) ? 4'd0 : node.leaf_class;
            depth_out_q <= depth_q;
         end
      end
   end

   assign bus.busy      = (state_q == ST_WAIT) || (state_q == ST_EVAL);
   assign bus.done      = (state_q == ST_DONE);
   assign bus.rom_addr  = rom_addr_q;
   assign bus.class_out = class_q;
   assign bus.err       = err_q;
   assign bus.depth_out = depth_out_q;

endmodule

// File: tb/tb_tree_walker_20.sv
// Bench for tree_walker_20: directed vector table, multi-cycle sequences and
// random trees checked against a real-valued reference walk.
module tb_tree_walker_20;
   localparam int NF = 8;
   localparam logic [63:0] D_192_5 = 64'h4068100000000000;
   localparam logic [63:0] D_193   = 64'h4068200000000000;
   localparam logic [63:0] D_PZERO = 64'h0000000000000000;
   localparam logic [63:0] D_NZERO = 64'h8000000000000000;
   localparam logic [63:0] D_NAN   = 64'h7FF8000000000001;
   localparam logic [63:0] D_PINF  = 64'h7FF0000000000000;
   localparam logic [63:0] D_NINF  = 64'hFFF0000000000000;
   localparam logic [63:0] D_ONE   = 64'h3FF0000000000000;
   localparam logic [63:0] D_MONE  = 64'hBFF0000000000000;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   logic [119:0] rom [1024];

   always #5 clk = ~clk;

   tree_walker_20_if #(.NODE_WIDTH(120), .ADDR_WIDTH(10), .NUM_FEATURES(NF)) bus ();

   tree_walker_20 #(.NUM_FEATURES(NF)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always_ff @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

   typedef struct {
      string        name;
      logic [119:0] root;
      logic [63:0]  feat;
      int           cls;
      int           err;
      int           dep;
   } vec_t;

   function automatic logic [119:0] mk_node(input int id, input int fidx, input logic [63:0] thr,
                                            input int l, input int r, input int leaf, input int cls);
      return {12'(id), 4'(fidx), thr, 12'(l), 12'(r), 11'd0, 1'(leaf), 4'(cls)};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: follow the tree using real-number comparison of the doubles.
   function automatic void ref_walk(input logic [NF*64-1:0] fv, output int cls, output int er, output int dep);
      int addr;
      int child;
      logic [119:0] n;
      logic [63:0] f;
      addr = 0; dep = 0; cls = 0; er = 0;
      for (int step = 0; step < 100; step++) begin
         n = rom[addr];
         if (int'(n[119:108]) != addr) begin er = 1; return; end
         if (n[4]) begin cls = int'(n[3:0]); return; end
         if (int'(n[107:104]) >= NF) begin er = 1; return; end
         f = fv[int'(n[107:104])*64 +: 64];
         child = ($bitstoreal(f) <= $bitstoreal(n[103:40])) ? int'(n[39:28]) : int'(n[27:16]);
         if (child >= 512) begin er = 1; return; end
         if (dep == 32) begin er = 1; return; end
         addr = child;
         dep++;
      end
   endfunction

   task automatic walk(input string nm, input logic [NF*64-1:0] fv, input int e_cls, input int e_err, input int e_dep);
      int cyc;
      bit seen;
      bit busy_ok;
      @(negedge clk);
      bus.feat_in = fv;
      bus.start   = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      cyc = 0; seen = 0; busy_ok = 1;
      while (!seen && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (bus.done) seen = 1;
         else if (!bus.busy) busy_ok = 0;
      end
      if (seen && bus.busy) busy_ok = 0;
      chk({nm, "_done"}, 64'(seen), 64'd1);
      chk({nm, "_lat"}, 64'(cyc), 64'(2*e_dep+3));
      chk({nm, "_class"}, 64'(bus.class_out), 64'(e_cls));
      chk({nm, "_err"}, 64'(bus.err), 64'(e_err));
      chk({nm, "_depth"}, 64'(bus.depth_out), 64'(e_dep));
      chk({nm, "_busy"}, 64'(busy_ok), 64'd1);
   endtask

   function automatic logic [63:0] pick_val();
      case ($urandom_range(0, 11))
         0:  return D_PZERO;
         1:  return D_NZERO;
         2:  return D_ONE;
         3:  return D_MONE;
         4:  return D_192_5;
         5:  return D_193;
         6:  return D_PINF;
         7:  return D_NINF;
         8:  return D_NAN;
         9:  return 64'h8000000000000001;
         default: return {$urandom(), $urandom()};
      endcase
   endfunction

   vec_t vecs [11];

   initial begin
      int cyc, d1, d2, c1, c2, ndone, r_cls, r_err, r_dep;
      logic [NF*64-1:0] fv;

      for (int a = 0; a < 1024; a++) rom[a] = '0;
      rom[1] = mk_node(1, 0, 64'd0, 0, 0, 1, 1);
      rom[2] = mk_node(2, 0, 64'd0, 0, 0, 1, 0);
      rom[3] = mk_node(3, 0, 64'd0, 0, 0, 1, 5);
      rom[4] = mk_node(4, 0, 64'd0, 0, 0, 1, 9);

      vecs[0]  = '{"root_leaf",  mk_node(0, 0, 64'd0, 0, 0, 1, 1),       D_ONE,   1, 0, 0};
      vecs[1]  = '{"thr_equal",  mk_node(0, 1, D_192_5, 1, 2, 0, 0),     D_192_5, 1, 0, 1};
      vecs[2]  = '{"thr_above",  mk_node(0, 1, D_192_5, 1, 2, 0, 0),     D_193,   0, 0, 1};
      vecs[3]  = '{"negzero",    mk_node(0, 2, D_PZERO, 3, 4, 0, 0),     D_NZERO, 5, 0, 1};
      vecs[4]  = '{"nan_right",  mk_node(0, 2, D_PZERO, 3, 4, 0, 0),     D_NAN,   9, 0, 1};
      vecs[5]  = '{"ninf_left",  mk_node(0, 3, D_MONE, 3, 4, 0, 0),      D_NINF,  5, 0, 1};
      vecs[6]  = '{"pinf_eq",    mk_node(0, 7, D_PINF, 3, 4, 0, 0),      D_PINF,  5, 0, 1};
      vecs[7]  = '{"bad_id",     mk_node(0, 0, D_ONE, 300, 300, 0, 0),   D_ONE,   0, 1, 1};
      vecs[8]  = '{"bad_feat",   mk_node(0, 15, D_ONE, 1, 1, 0, 0),      D_ONE,   0, 1, 0};
      vecs[9]  = '{"bad_child",  mk_node(0, 0, D_ONE, 600, 600, 0, 0),   D_ONE,   0, 1, 0};
      vecs[10] = '{"self_loop",  mk_node(0, 0, D_ONE, 0, 0, 0, 0),       D_ONE,   0, 1, 32};

      rst = 1'b1;
      bus.start = 1'b0;
      bus.feat_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_err", 64'(bus.err), 64'd0);
      chk("rst_class", 64'(bus.class_out), 64'd0);
      chk("rst_depth", 64'(bus.depth_out), 64'd0);
      chk("rst_addr", 64'(bus.rom_addr), 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         rom[0] = vecs[i].root;
         walk(vecs[i].name, {NF{vecs[i].feat}}, vecs[i].cls, vecs[i].err, vecs[i].dep);
      end

      // start held high across two walks, feature changed after the first done
      rom[0] = mk_node(0, 1, D_192_5, 1, 2, 0, 0);
      @(negedge clk);
      bus.feat_in = {NF{D_192_5}};
      bus.start = 1'b1;
      cyc = 0; d1 = -1; d2 = -1; c1 = -1; c2 = -1; ndone = 0;
      while (cyc < 40 && d2 < 0) begin
         @(negedge clk);
         cyc++;
         if (bus.done) begin
            ndone++;
            if (d1 < 0) begin d1 = cyc; c1 = int'(bus.class_out); bus.feat_in = {NF{D_193}}; end
            else begin d2 = cyc; c2 = int'(bus.class_out); end
         end
      end
      bus.start = 1'b0;
      chk("hold_done1_cyc", 64'(d1), 64'd5);
      chk("hold_class1", 64'(c1), 64'd1);
      chk("hold_done2_cyc", 64'(d2), 64'd11);
      chk("hold_class2", 64'(c2), 64'd0);
      chk("hold_ndone", 64'(ndone), 64'd2);
      repeat (3) @(negedge clk);
      chk("hold_no_extra", 64'(bus.busy), 64'd0);

      // reset while waiting on the fourth node (depth 3)
      rom[0]  = mk_node(0, 0, D_ONE, 20, 2, 0, 0);
      rom[20] = mk_node(20, 1, D_ONE, 21, 2, 0, 0);
      rom[21] = mk_node(21, 2, D_ONE, 22, 2, 0, 0);
      rom[22] = mk_node(22, 0, 64'd0, 0, 0, 1, 7);
      @(negedge clk);
      bus.feat_in = '0;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (7) @(negedge clk);
      chk("mid_busy", 64'(bus.busy), 64'd1);
      chk("mid_addr", 64'(bus.rom_addr), 64'd22);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", 64'(bus.busy), 64'd0);
      chk("midrst_done", 64'(bus.done), 64'd0);
      chk("midrst_addr", 64'(bus.rom_addr), 64'd0);
      chk("midrst_depth", 64'(bus.depth_out), 64'd0);
      chk("midrst_class", 64'(bus.class_out), 64'd0);
      rst = 1'b0;
      ndone = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      chk("midrst_no_done", 64'(ndone), 64'd0);
      walk("after_rst", '0, 7, 0, 3);

      // random trees over addresses 0..15
      for (int i = 0; i < 40; i++) begin
         if (i % 5 == 0) begin
            for (int a = 0; a < 16; a++) begin
               int id;
               id = ($urandom_range(0, 19) == 0) ? (a ^ 1) : a;
               if ($urandom_range(0, 9) < 3)
                  rom[a] = mk_node(id, $urandom_range(0, 15), pick_val(), 0, 0, 1, $urandom_range(0, 15));
               else
                  rom[a] = mk_node(id,
                                   ($urandom_range(0, 9) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7),
                                   pick_val(),
                                   ($urandom_range(0, 19) == 0) ? 600 : $urandom_range(0, 15),
                                   ($urandom_range(0, 19) == 0) ? 600 : $urandom_range(0, 15),
                                   0, 0);
            end
         end
         for (int k = 0; k < NF; k++) fv[k*64 +: 64] = pick_val();
         ref_walk(fv, r_cls, r_err, r_dep);
         walk($sformatf("rnd%0d", i), fv, r_cls, r_err, r_dep);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
